// File: rtl/mod_reduct_64bgoldilocks_pipe_pkg.sv
// rtl/mod_reduct_64bgoldilocks_pipe_pkg.sv - Goldilocks field constants and latency helper
// Shared by the reduction datapath, its pipeline wrapper and parent modules.
package mod_reduct_64bgoldilocks_pipe_pkg;

  typedef logic [63:0]  gl_word_t;
  typedef logic [127:0] gl_wide_t;

  localparam gl_word_t GOLDILOCKS_P = 64'hFFFF_FFFF_0000_0001;
  localparam gl_word_t EPS          = 64'h0000_0000_FFFF_FFFF;

  localparam int                 LAT_MAX         = 3;
  localparam logic [LAT_MAX-1:0] LAT_PIPE_MH_DEF = 3'b111;

  function automatic int get_latency(input int in_pipe, input logic [LAT_MAX-1:0] lat_pipe_mh);
    int n;
    n = (in_pipe != 0) ? 1 : 0;
    for (int k = 0; k < LAT_MAX; k++) begin
      if (lat_pipe_mh[k]) n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/goldilocks_fold_core.sv
// rtl/goldilocks_fold_core.sv - combinational fold/accumulate/canonicalise for one lane
// The three sections are exposed separately so the wrapper can register between them.
module goldilocks_fold_core
  import mod_reduct_64bgoldilocks_pipe_pkg::*;
(
  input  logic [127:0] a_i,
  output logic [63:0]  t0_o,
  output logic [63:0]  t1_o,
  input  logic [63:0]  t0_i,
  input  logic [63:0]  t1_i,
  output logic [63:0]  r_o,
  input  logic [63:0]  r_i,
  output logic [63:0]  z_o
);

  logic [63:0] l;
  logic [31:0] h0;
  logic [31:0] h1;
  logic [64:0] diff;
  logic [64:0] sum;
  logic [64:0] canon;

  // 2^64 == EPS and 2^96 == -1 (mod p), so a == l - h1 + h0*EPS.
  always_comb begin
    l     = a_i[63:0];
    h0    = a_i[95:64];
    h1    = a_i[127:96];
    diff  = {1'b0, l} - {33'b0, h1};
    t0_o  = diff[64] ? (diff[63:0] - EPS) : diff[63:0];
    t1_o  = {h0, 32'b0} - {32'b0, h0};
    sum   = {1'b0, t0_i} + {1'b0, t1_i};
    r_o   = sum[64] ? (sum[63:0] + EPS) : sum[63:0];
    canon = {1'b0, r_i} - {1'b0, GOLDILOCKS_P};
    z_o   = canon[64] ? r_i : canon[63:0];
  end

endmodule

// File: rtl/mod_reduct_64bgoldilocks_pipe.sv
// rtl/mod_reduct_64bgoldilocks_pipe.sv - multi-lane pipelined 128-bit mod Goldilocks reduction
// Stage 0 is the optional input register; stages 1..LAT_MAX follow the LAT_PIPE_MH bits.
module mod_reduct_64bgoldilocks_pipe
  import mod_reduct_64bgoldilocks_pipe_pkg::*;
#(
  parameter int                 NB_CHAN     = 1,
  parameter int                 IN_PIPE     = 1,
  parameter logic [LAT_MAX-1:0] LAT_PIPE_MH = LAT_PIPE_MH_DEF,
  parameter int                 SIDE_W      = 0,
  parameter int                 RST_SIDE    = 0
) (
  input  logic                                clk,
  input  logic                                a_rst_n,
  input  logic [NB_CHAN*128-1:0]              a,
  input  logic                                a_avail,
  input  logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] a_side,
  output logic [NB_CHAN*64-1:0]               z,
  output logic                                z_avail,
  output logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] z_side
);

  localparam int               SW     = (SIDE_W > 0) ? SIDE_W : 1;
  localparam logic [LAT_MAX:0] STG_EN = {LAT_PIPE_MH, (IN_PIPE != 0)};

  logic [LAT_MAX:0]   av_q;
  logic [LAT_MAX+1:0] av;
  logic [SW-1:0]      sd_q [LAT_MAX+1];
  logic [SW-1:0]      sd   [LAT_MAX+2];

  // av[s] is the avail entering stage s; unregistered stages pass straight through.
  always_comb begin
    av[0] = a_avail & a_rst_n;
    sd[0] = a_side;
    for (int s = 0; s <= LAT_MAX; s++) begin
      av[s+1] = STG_EN[s] ? av_q[s] : av[s];
      sd[s+1] = STG_EN[s] ? sd_q[s] : sd[s];
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      av_q <= '0;
    end else begin
      for (int s = 0; s <= LAT_MAX; s++) av_q[s] <= STG_EN[s] & av[s];
    end
  end

  if (RST_SIDE != 0) begin : g_side_rst
    always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
        for (int s = 0; s <= LAT_MAX; s++) sd_q[s] <= '0;
      end else begin
        for (int s = 0; s <= LAT_MAX; s++) begin
          if (STG_EN[s] && av[s]) sd_q[s] <= sd[s];
        end
      end
    end
  end else begin : g_side_nrst
    always_ff @(posedge clk) begin
      for (int s = 0; s <= LAT_MAX; s++) begin
        if (STG_EN[s] && av[s]) sd_q[s] <= sd[s];
      end
    end
  end

  assign z_avail = av[LAT_MAX+1];
  assign z_side  = sd[LAT_MAX+1];

  for (genvar ch = 0; ch < NB_CHAN; ch++) begin : g_lane
    logic [127:0] a_d;
    logic [127:0] a_s;
    logic [63:0]  t0_d;
    logic [63:0]  t1_d;
    logic [63:0]  t0_s;
    logic [63:0]  t1_s;
    logic [63:0]  r_d;
    logic [63:0]  r_s;
    logic [63:0]  z_d;
    logic [63:0]  z_s;

    assign a_d = a[ch*128 +: 128];

    goldilocks_fold_core u_core (
      .a_i  (a_s),
      .t0_o (t0_d),
      .t1_o (t1_d),
      .t0_i (t0_s),
      .t1_i (t1_s),
      .r_o  (r_d),
      .r_i  (r_s),
      .z_o  (z_d)
    );

    if (STG_EN[0]) begin : g_in_reg
      logic [127:0] a_q;
      always_ff @(posedge clk) if (av[0]) a_q <= a_d;
      assign a_s = a_q;
    end else begin : g_in_wire
      assign a_s = a_d;
    end

    if (STG_EN[1]) begin : g_fold_reg
      logic [63:0] t0_q;
      logic [63:0] t1_q;
      always_ff @(posedge clk) begin
        if (av[1]) begin
          t0_q <= t0_d;
          t1_q <= t1_d;
        end
      end
      assign t0_s = t0_q;
      assign t1_s = t1_q;
    end else begin : g_fold_wire
      assign t0_s = t0_d;
      assign t1_s = t1_d;
    end

    if (STG_EN[2]) begin : g_acc_reg
      logic [63:0] r_q;
      always_ff @(posedge clk) if (av[2]) r_q <= r_d;
      assign r_s = r_q;
    end else begin : g_acc_wire
      assign r_s = r_d;
    end

    if (STG_EN[3]) begin : g_can_reg
      logic [63:0] z_q;
      always_ff @(posedge clk) if (av[3]) z_q <= z_d;
      assign z_s = z_q;
    end else begin : g_can_wire
      assign z_s = z_d;
    end

    assign z[ch*64 +: 64] = z_s;
  end

endmodule

// File: tb/tb_mod_reduct_64bgoldilocks_pipe.sv
// tb/tb_mod_reduct_64bgoldilocks_pipe.sv - self-checking bench for the Goldilocks reduction pipeline
module tb_mod_reduct_64bgoldilocks_pipe;
  import mod_reduct_64bgoldilocks_pipe_pkg::*;

  localparam logic [63:0] P  = 64'hFFFF_FFFF_0000_0001;
  localparam int          NV = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [127:0] d_a;
  logic         d_av;
  logic         d_side;
  logic [63:0]  d_z;
  logic         d_zav;
  logic         d_zside;

  mod_reduct_64bgoldilocks_pipe u_def (
    .clk(clk), .a_rst_n(rst_n), .a(d_a), .a_avail(d_av), .a_side(d_side),
    .z(d_z), .z_avail(d_zav), .z_side(d_zside)
  );

  logic [127:0] v_a;
  logic         v_av;
  logic         v_side;
  logic [63:0]  v_z     [NV];
  logic         v_zav   [NV];
  logic         v_zside [NV];

  for (genvar g = 0; g < NV; g++) begin : g_var
    localparam int         IP = g / 3;
    localparam logic [2:0] LM = (g % 3 == 0) ? 3'b000 : ((g % 3 == 1) ? 3'b101 : 3'b111);
    mod_reduct_64bgoldilocks_pipe #(.IN_PIPE(IP), .LAT_PIPE_MH(LM)) u_dut (
      .clk(clk), .a_rst_n(rst_n), .a(v_a), .a_avail(v_av), .a_side(v_side),
      .z(v_z[g]), .z_avail(v_zav[g]), .z_side(v_zside[g])
    );
  end

  logic [511:0] m_a;
  logic         m_av;
  logic [7:0]   m_side;
  logic [255:0] m_z;
  logic         m_zav;
  logic [7:0]   m_zside;

  mod_reduct_64bgoldilocks_pipe #(.NB_CHAN(4), .SIDE_W(8), .RST_SIDE(1)) u_mc (
    .clk(clk), .a_rst_n(rst_n), .a(m_a), .a_avail(m_av), .a_side(m_side),
    .z(m_z), .z_avail(m_zav), .z_side(m_zside)
  );

  function automatic logic [63:0] ref_mod(input logic [127:0] x);
    logic [127:0] r;
    r = x % {64'b0, P};
    return r[63:0];
  endfunction

  function automatic logic [2:0] lm_of(input int g);
    return (g % 3 == 0) ? 3'b000 : ((g % 3 == 1) ? 3'b101 : 3'b111);
  endfunction

  function automatic int lat_of(input int g);
    int ones [3];
    ones = '{0, 2, 3};
    return (g / 3) + ones[g % 3];
  endfunction

  function automatic logic [127:0] rand_operand();
    logic [127:0] x;
    int k;
    k = $urandom_range(0, 7);
    x = {$urandom(), $urandom(), $urandom(), $urandom()};
    case (k)
      0: x = '1;
      1: x = {64'b0, P} + 128'($urandom_range(0, 4)) - 128'd2;
      2: x[63:0] = '0;
      3: x[127:64] = '1;
      default: ;
    endcase
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    d_av = 1'b0; v_av = 1'b0; m_av = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    d_a = '1; d_av = 1'b1; v_a = '1; v_av = 1'b1; m_a = '1; m_av = 1'b1; m_side = 8'h5A;
    repeat (3) begin
      tick();
      #3;
      total++; if (d_zav !== 1'b0) begin bad++; $display("FAIL rst_def_zav got=%b want=0", d_zav); end
      total++; if (m_zav !== 1'b0) begin bad++; $display("FAIL rst_mc_zav got=%b want=0", m_zav); end
      total++; if (m_zside !== 8'h00) begin bad++; $display("FAIL rst_mc_zside got=%h want=00", m_zside); end
      for (int g = 0; g < NV; g++) begin
        total++; if (v_zav[g] !== 1'b0) begin bad++; $display("FAIL rst_var%0d_zav got=%b want=0", g, v_zav[g]); end
      end
    end
    tick();
    rst_n = 1'b1; d_av = 1'b0; v_av = 1'b0; m_av = 1'b0;
    #3;
    total++; if (d_zav !== 1'b0) begin bad++; $display("FAIL rel_def_zav got=%b want=0", d_zav); end
    total++; if (m_zav !== 1'b0) begin bad++; $display("FAIL rel_mc_zav got=%b want=0", m_zav); end
    for (int g = 0; g < NV; g++) begin
      total++;
      if (get_latency(g / 3, lm_of(g)) !== lat_of(g)) begin
        bad++; $display("FAIL get_latency%0d got=%0d want=%0d", g, get_latency(g / 3, lm_of(g)), lat_of(g));
      end
    end
    idle(6);
  endtask

  task automatic test_values();
    logic [127:0] ins [3];
    ins = '{128'd0, {64'b0, P}, {63'b0, P, 1'b0}};
    for (int c = 0; c < 10; c++) begin
      tick();
      d_av = (c < 3);
      d_a  = (c < 3) ? ins[c] : '0;
      #3;
      total++;
      if (d_zav !== ((c >= 4) && (c <= 6))) begin bad++; $display("FAIL vals_zav c=%0d got=%b", c, d_zav); end
      if ((c >= 4) && (c <= 6)) begin
        total++; if (d_z !== 64'd0) begin bad++; $display("FAIL vals_z c=%0d got=%h want=0", c, d_z); end
      end
    end
    idle(2);
  endtask

  task automatic test_boundaries();
    logic [127:0] ins [5];
    logic [63:0]  exp [5];
    ins = '{128'd1 << 64, 128'd1 << 96, '1, {64'b0, P} - 128'd1, {64'b0, P} + 128'd5};
    exp = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFE_0000_0000,
            64'hFFFF_FFFF_0000_0000, 64'd5};
    for (int c = 0; c < 12; c++) begin
      tick();
      d_av = (c < 5);
      d_a  = (c < 5) ? ins[c] : '0;
      #3;
      total++;
      if (d_zav !== ((c >= 4) && (c < 9))) begin bad++; $display("FAIL bnd_zav c=%0d got=%b", c, d_zav); end
      if ((c >= 4) && (c < 9)) begin
        total++;
        if (d_z !== exp[c-4]) begin bad++; $display("FAIL bnd_z%0d got=%h want=%h", c - 4, d_z, exp[c-4]); end
      end
    end
  endtask

  task automatic test_variants(input int n);
    logic [127:0] ha [];
    logic         hv [];
    logic         ev;
    int           lt;
    ha = new[n + 8];
    hv = new[n + 8];
    for (int c = 0; c < n + 8; c++) begin
      tick();
      if (c < n) begin
        v_av = 1'($urandom_range(0, 1));
        v_a  = rand_operand();
      end else begin
        v_av = 1'b0;
      end
      ha[c] = v_a;
      hv[c] = v_av;
      #3;
      for (int g = 0; g < NV; g++) begin
        lt = lat_of(g);
        ev = (c >= lt) ? hv[c-lt] : 1'b0;
        total++;
        if (v_zav[g] !== ev) begin bad++; $display("FAIL var%0d_zav c=%0d got=%b want=%b", g, c, v_zav[g], ev); end
        if (ev) begin
          total++;
          if (v_z[g] !== ref_mod(ha[c-lt])) begin
            bad++; $display("FAIL var%0d_z c=%0d got=%h want=%h", g, c, v_z[g], ref_mod(ha[c-lt]));
          end
        end
      end
    end
  endtask

  task automatic test_multichan(input int n);
    logic [511:0] ha [];
    logic         hv [];
    logic [7:0]   in_cnt;
    logic [7:0]   out_cnt;
    ha = new[n + 8];
    hv = new[n + 8];
    in_cnt = 8'd0;
    out_cnt = 8'd0;
    for (int c = 0; c < n + 8; c++) begin
      tick();
      m_av = (c < n) ? 1'($urandom_range(0, 1)) : 1'b0;
      for (int ch = 0; ch < 4; ch++) m_a[ch*128 +: 128] = rand_operand();
      m_side = in_cnt;
      if (m_av) in_cnt = in_cnt + 8'd1;
      ha[c] = m_a;
      hv[c] = m_av;
      #3;
      total++;
      if (m_zav !== ((c >= 4) ? hv[c-4] : 1'b0)) begin bad++; $display("FAIL mc_zav c=%0d got=%b", c, m_zav); end
      if ((c >= 4) && hv[c-4]) begin
        for (int ch = 0; ch < 4; ch++) begin
          total++;
          if (m_z[ch*64 +: 64] !== ref_mod(ha[c-4][ch*128 +: 128])) begin
            bad++; $display("FAIL mc_z lane%0d c=%0d got=%h want=%h", ch, c, m_z[ch*64 +: 64], ref_mod(ha[c-4][ch*128 +: 128]));
          end
        end
        total++;
        if (m_zside !== out_cnt) begin bad++; $display("FAIL mc_zside c=%0d got=%0d want=%0d", c, m_zside, out_cnt); end
        out_cnt = out_cnt + 8'd1;
      end
    end
    total++;
    if (out_cnt !== in_cnt) begin bad++; $display("FAIL mc_count got=%0d want=%0d", out_cnt, in_cnt); end
  endtask

  task automatic test_reset_midstream();
    logic [127:0] x;
    x = {32'hDEAD_BEEF, 32'h1234_5678, 64'hFFFF_FFFF_FFFF_FFFF};
    for (int c = 0; c < 17; c++) begin
      tick();
      d_av  = (c < 3) || (c == 10);
      d_a   = (c == 10) ? x : rand_operand();
      rst_n = (c != 3);
      #3;
      total++;
      if (d_zav !== (c == 14)) begin bad++; $display("FAIL mid_zav c=%0d got=%b want=%b", c, d_zav, (c == 14)); end
      if (c == 14) begin
        total++;
        if (d_z !== ref_mod(x)) begin bad++; $display("FAIL mid_z got=%h want=%h", d_z, ref_mod(x)); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    d_a = '0; d_av = 1'b0; d_side = 1'b0;
    v_a = '0; v_av = 1'b0; v_side = 1'b0;
    m_a = '0; m_av = 1'b0; m_side = '0;
    test_reset();
    test_values();
    test_boundaries();
    test_variants(10000);
    test_multichan(300);
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_reduct_64bgoldilocks_pipe.md
MOD_REDUCT_64BGOLDILOCKS_PIPE -- requirements
Module: mod_reduct_64bgoldilocks_pipe

Interface
REQ-001 SHALL have parameter NB_CHAN, default 1: number of independent reduction lanes sharing one avail.
REQ-002 SHALL have parameter IN_PIPE, default 1: 1 inserts an input register stage, 0 means no input register.
REQ-003 SHALL have parameter LAT_PIPE_MH, default 3'b111: one bit per internal stage (fold, accumulate, canonicalise); 1 means that stage is registered.
REQ-004 SHALL have parameter SIDE_W, default 0: width of the side data carried alongside the result; 0 means no side path.
REQ-005 SHALL have parameter RST_SIDE, default 0: 1 means side registers are reset.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port a_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port a, input, NB_CHAN x 128 bits: operand to reduce, one per lane.
REQ-009 SHALL have port a_avail, input, 1 bit: qualifies a and a_side.
REQ-010 SHALL have port a_side, input, SIDE_W bits: side data.
REQ-011 SHALL have port z, output, NB_CHAN x 64 bits: a mod p per lane, with p = 2^64 - 2^32 + 1.
REQ-012 SHALL have port z_avail, output, 1 bit.
REQ-013 SHALL have port z_side, output, SIDE_W bits.

Function
REQ-014 SHALL make the latency from a_avail to z_avail exactly IN_PIPE + countones(LAT_PIPE_MH) cycles; with all bits zero the path is combinational.
REQ-015 SHALL use no backpressure: every a_avail=1 cycle produces exactly one z_avail=1 cycle, with no bubbles inserted or removed, and back-to-back inputs give back-to-back outputs.
REQ-016 SHALL split the operand as a = h1*2^96 + h0*2^64 + l, with l 64 bits and h0, h1 32 bits each; EPS = 2^32 - 1.
REQ-017 SHALL compute fold stage t0 = l - h1, subtracting EPS when that subtraction borrows, and t1 = h0*EPS; only shift and subtract are used, no multiplier.
REQ-018 SHALL compute accumulate stage r = t0 + t1 on 64 bits, adding EPS when the addition carries.
REQ-019 SHALL have the canonicalise stage output r - p when r >= p, else r, so z is always in [0, p-1] for every 128-bit input, including 2^128 - 1.
REQ-020 SHALL reduce each lane independently, with all lanes sharing the avail and side pipeline.
REQ-021 SHALL delay z_side by the same latency as z and align it with z_avail.
REQ-022 SHALL leave z and z_side don't-care when z_avail=0; data registers load only when their stage avail is 1 (power saving).
REQ-023 SHALL make the package function get_latency(IN_PIPE, LAT_PIPE_MH) return the exact REQ-014 value for parent modules.

Reset
REQ-024 SHALL clear every avail pipeline register asynchronously on a_rst_n=0, so z_avail=0 during reset and on the first cycle after release.
REQ-025 SHALL make inputs presented during reset produce no output; data in flight when reset asserts mid-operation is discarded and never reaches z_avail=1.
REQ-026 SHALL leave data registers unreset, and reset side registers to 0 only when RST_SIDE=1.

Structure
REQ-027 SHALL place in package mod_reduct_64bgoldilocks_pipe_pkg: GOLDILOCKS_P, EPS, LAT_MAX=3, default LAT_PIPE_MH, and get_latency.
REQ-028 SHALL use one sub-module, goldilocks_fold_core: a combinational per-lane fold/accumulate/canonicalise datapath, instantiated NB_CHAN times, with stage registers and the avail/side pipeline in the top.
REQ-029 SHALL implement the pipeline with generate per LAT_PIPE_MH bit, without hard-coded stage counts.

Verification
REQ-030 SHALL cover reset plus value test (defaults): a = 0, p, 2p in consecutive cycles give z = 0, 0, 0 on three consecutive z_avail cycles at latency 4.
REQ-031 SHALL cover boundaries: a = 2^64 gives 0x00000000FFFFFFFF; a = 2^96 gives 0xFFFFFFFF00000000; a = 2^128 - 1 gives 0xFFFFFFFE00000000; a = p - 1 gives 0xFFFFFFFF00000000.
REQ-032 SHALL cover pipeline variants: LAT_PIPE_MH in {000, 101, 111} with IN_PIPE in {0, 1}, 10k random a with random a_avail, checking z against a reference model and z_avail against get_latency.
REQ-033 SHALL cover NB_CHAN=4, SIDE_W=8: distinct random operands per lane with a_side = a count; each lane matches the model and z_side returns the count in order.
REQ-034 SHALL cover reset mid-stream: assert a_rst_n for 1 cycle while 3 inputs are in flight; no z_avail for them, and the first post-reset input emerges after exactly the latency.
